// File: rtl/ipf_driver.sv
// Host-side driver for the IPF convolution engine: buffers an image window and weight list,
// sequences one session, collects results into a FIFO and polices the engine's handshake.
module ipf_driver #(
   parameter int unsigned MAX_W     = 8,
   parameter int unsigned RES_DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic                       ld_sel,
   input  logic [$clog2(MAX_W)-1:0]   ld_addr,
   input  logic [7:0]                 ld_data,
   input  logic                       start,
   input  logic [$clog2(MAX_W):0]     num_w,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       ipf_ready,
   output logic [7:0]                 ipf_i_data,
   output logic [3:0]                 ipf_w_data,
   output logic                       ipf_endinput,
   output logic                       ipf_rst,
   input  logic [31:0]                ipf_res,
   input  logic                       ipf_res_valid,
   input  logic                       ipf_finish,
   output logic [31:0]                out_data,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int unsigned AW = $clog2(MAX_W);
   localparam int unsigned FW = $clog2(RES_DEPTH);
   localparam int unsigned CW = $clog2(RES_DEPTH + 1);
   localparam logic [AW:0]   KOne    = 1;
   localparam logic [FW-1:0] PtrOne  = 1;
   localparam logic [FW-1:0] PtrLast = FW'(RES_DEPTH - 1);
   localparam logic [CW-1:0] CntOne  = 1;
   localparam logic [CW-1:0] CntFull = CW'(RES_DEPTH);

   typedef enum logic [2:0] {StIdle, StKick, StSendI, StSendW, StComp, StClose, StRearm} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [AW:0] k_q, k_d, n_q, n_d;

   logic [7:0]  img_q [3];
   logic [3:0]  wbuf_q [MAX_W];
   logic [31:0] mem_q [RES_DEPTH];
   logic [FW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] fifo_cnt_q;
   logic        err_q, err_d, err_set;

   logic        ready_q, ready_d, end_q, end_d, irst_q, irst_d, done_q, done_d;
   logic [7:0]  idata_q, idata_d;
   logic [3:0]  wdata_q, wdata_d;

   logic [31:0] ld_addr_ext, free_ent;
   logic        load_en, accept, fifo_full, fifo_empty, push_ok, pop_ok;

   assign ld_addr_ext = 32'(ld_addr);
   assign ld_ready    = (state_q == StIdle) && !rst;
   assign load_en     = ld_valid && ld_ready;
   assign fifo_full   = (fifo_cnt_q == CntFull);
   assign fifo_empty  = (fifo_cnt_q == '0);
   assign free_ent    = RES_DEPTH - 32'(fifo_cnt_q);
   assign push_ok     = ipf_res_valid && !fifo_full;
   assign pop_ok      = out_ready && !fifo_empty;
   // Admission guarantees the whole session's results fit, so capture never back-pressures.
   assign accept      = start && (state_q == StIdle) && (num_w != '0) &&
                        (32'(num_w) <= MAX_W) && (free_ent >= 3 * 32'(num_w));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         k_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         n_q     <= n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      n_d     = n_q;
      case (state_q)
         StIdle: if (accept) begin
            state_d = StKick;
            n_d     = num_w;
            k_d     = '0;
         end
         StKick: begin
            state_d = StSendI;
            cnt_d   = '0;
         end
         StSendI: if (cnt_q == 2'd2) state_d = StSendW;
                  else cnt_d = cnt_q + 2'd1;
         StSendW: begin
            state_d = StComp;
            cnt_d   = '0;
         end
         StComp: if (cnt_q == 2'd2) begin
            if (k_q == n_q - KOne) state_d = StClose;
            else begin
               state_d = StSendW;
               k_d     = k_q + KOne;
            end
         end else cnt_d = cnt_q + 2'd1;
         StClose: state_d = StRearm;
         StRearm: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // IPF-side outputs are decoded from the next state so they are registered yet aligned.
   always_comb begin
      ready_d = (state_d == StKick);
      idata_d = idata_q;
      if (state_d == StSendI) idata_d = img_q[cnt_d];
      wdata_d = wdata_q;
      if (state_d == StSendW) wdata_d = wbuf_q[k_d[AW-1:0]];
      end_d   = (state_d == StComp) && (cnt_d == 2'd2) && (k_d == n_d - KOne);
      irst_d  = (state_d == StRearm);
      done_d  = (state_d == StRearm);
   end

   always_comb begin
      err_set = ((state_q == StComp) && !ipf_res_valid) ||
                ((state_q != StComp) && ipf_res_valid) ||
                ((state_q == StClose) && !ipf_finish) ||
                (ipf_finish && (state_q inside {StKick, StSendI, StSendW, StComp})) ||
                (ipf_res_valid && fifo_full);
      err_d   = (accept ? 1'b0 : err_q) | err_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q    <= 1'b0;
         idata_q    <= '0;
         wdata_q    <= '0;
         end_q      <= 1'b0;
         irst_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         img_q      <= '{default: '0};
         wbuf_q     <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         ready_q <= ready_d;
         idata_q <= idata_d;
         wdata_q <= wdata_d;
         end_q   <= end_d;
         irst_q  <= irst_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (load_en && !ld_sel && (ld_addr_ext[1:0] != 2'd3)) img_q[ld_addr_ext[1:0]] <= ld_data;
         if (load_en && ld_sel && (ld_addr_ext < MAX_W)) wbuf_q[ld_addr] <= ld_data[3:0];
         if (push_ok) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
         if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
         if (push_ok && !pop_ok)      fifo_cnt_q <= fifo_cnt_q + CntOne;
         else if (!push_ok && pop_ok) fifo_cnt_q <= fifo_cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= ipf_res;
   end

   assign busy         = (state_q != StIdle);
   assign done         = done_q;
   assign err          = err_q;
   assign ipf_ready    = ready_q;
   assign ipf_i_data   = idata_q;
   assign ipf_w_data   = wdata_q;
   assign ipf_endinput = end_q;
   assign ipf_rst      = irst_q;
   assign out_valid    = !fifo_empty;
   assign out_data     = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ipf_driver.sv
// Directed bench for ipf_driver: a cycle-timed IPF responder plus per-scenario checks.
module tb_ipf_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0, ld_ready, ld_sel = 1'b0;
   logic [2:0]  ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        start = 1'b0;
   logic [3:0]  num_w = '0;
   logic        busy, done, err, ipf_ready, ipf_endinput, ipf_rst;
   logic [7:0]  ipf_i_data;
   logic [3:0]  ipf_w_data;
   logic [31:0] ipf_res = '0;
   logic        ipf_res_valid = 1'b0, ipf_finish = 1'b0;
   logic [31:0] out_data;
   logic        out_valid, out_ready = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [63:0] v_ready, v_end, v_done, v_irst, v_busy, v_err;
   logic [7:0]  v_idata [64];
   logic [3:0]  v_wdata [64];
   logic        snap_zero;

   ipf_driver #(.MAX_W(8), .RES_DEPTH(32)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
      .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .num_w(num_w), .busy(busy),
      .done(done), .err(err), .ipf_ready(ipf_ready), .ipf_i_data(ipf_i_data),
      .ipf_w_data(ipf_w_data), .ipf_endinput(ipf_endinput), .ipf_rst(ipf_rst),
      .ipf_res(ipf_res), .ipf_res_valid(ipf_res_valid), .ipf_finish(ipf_finish),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic load(input logic sel, input logic [2:0] a, input logic [7:0] d);
      ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic pop(output logic v, output logic [31:0] d);
      v = out_valid; d = out_data; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] res_of(input int idx, input logic [31:0] r0,
                                          input logic [31:0] r1);
      int k;
      k = idx / 3;
      return (k == 0) ? r0 : r1 + 32'(k - 1);
   endfunction

   // Drives start at cycle T, then plays the IPF side by cycle offset from T and records outputs.
   task automatic session(input int n, input logic [31:0] r0, input logic [31:0] r1,
                          input bit give_fin, input int abort_at);
      int last;
      last = 4 * n + 7;
      v_ready = '0; v_end = '0; v_done = '0; v_irst = '0; v_busy = '0; v_err = '0;
      snap_zero = 1'b0;
      start = 1'b1; num_w = 4'(n);
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         start = 1'b0;
         if (abort_at != 0 && j == abort_at + 1) begin
            snap_zero = ({ld_ready, busy, done, err, ipf_ready, ipf_i_data, ipf_w_data,
                          ipf_endinput, ipf_rst, out_valid, out_data} == '0);
            rst = 1'b0;
            return;
         end
         v_ready[j] = ipf_ready; v_end[j] = ipf_endinput; v_done[j] = done;
         v_irst[j] = ipf_rst; v_busy[j] = busy; v_err[j] = err;
         v_idata[j] = ipf_i_data; v_wdata[j] = ipf_w_data;
         ipf_res_valid = (j >= 6) && (j <= 4 * n + 4) && (((j - 6) % 4) != 3);
         ipf_res = ipf_res_valid ? res_of(((j - 6) / 4) * 3 + (j - 6) % 4, r0, r1) : '0;
         ipf_finish = give_fin && (j == 4 * n + 5);
         if (abort_at != 0 && j == abort_at) begin
            rst = 1'b1; ipf_res_valid = 1'b0; ipf_finish = 1'b0;
         end
      end
      ipf_res_valid = 1'b0; ipf_finish = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      tests++;
      if ({ld_ready, busy, done, err, ipf_ready, ipf_i_data, ipf_w_data, ipf_endinput, ipf_rst,
           out_valid, out_data} !== '0) begin
         fails++; $display("FAIL reset_outputs: some output nonzero while rst high");
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({ld_ready, busy, out_valid} !== 3'b100) begin
         fails++; $display("FAIL reset_idle: {ld_ready,busy,out_valid}=%b want 100",
                           {ld_ready, busy, out_valid});
      end
   endtask

   task automatic test_single;
      logic v; logic [31:0] d;
      for (int i = 0; i < 3; i++) load(1'b0, 3'(i), 8'h55);
      load(1'b1, 3'd0, 8'h0F);
      session(1, 32'h3333_3333, 32'h0, 1'b1, 0);
      tests++;
      if (v_ready !== (64'd1 << 1)) begin
         fails++; $display("FAIL single_ready: got %h want %h", v_ready, 64'd1 << 1);
      end
      tests++;
      if ({v_idata[2], v_idata[3], v_idata[4], v_idata[5]} !== 32'h5555_5555) begin
         fails++; $display("FAIL single_idata: got %h want 55555555",
                           {v_idata[2], v_idata[3], v_idata[4], v_idata[5]});
      end
      tests++;
      if (v_wdata[5] !== 4'hF) begin
         fails++; $display("FAIL single_wdata: got %h want f", v_wdata[5]);
      end
      tests++;
      if (v_end !== (64'd1 << 8)) begin
         fails++; $display("FAIL single_endinput: got %h want %h", v_end, 64'd1 << 8);
      end
      tests++;
      if ({v_done, v_irst} !== {64'd1 << 10, 64'd1 << 10}) begin
         fails++; $display("FAIL single_done_rst: done %h rst %h want bit 10", v_done, v_irst);
      end
      tests++;
      if (v_busy !== 64'h7FE) begin
         fails++; $display("FAIL single_busy: got %h want 7fe", v_busy);
      end
      tests++;
      if (v_err !== '0) begin
         fails++; $display("FAIL single_err: got %h want 0", v_err);
      end
      for (int i = 0; i < 3; i++) begin
         pop(v, d);
         tests++;
         if ({v, d} !== {1'b1, 32'h3333_3333}) begin
            fails++; $display("FAIL single_fifo%0d: got %b/%h want 1/33333333", i, v, d);
         end
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL single_fifo_empty: out_valid %b want 0", out_valid);
      end
   endtask

   task automatic test_two;
      logic v; logic [31:0] d;
      for (int i = 0; i < 3; i++) load(1'b0, 3'(i), 8'hFF);
      load(1'b1, 3'd0, 8'h0A);
      load(1'b1, 3'd1, 8'h05);
      session(2, 32'h6666_6666, 32'h3333_3333, 1'b1, 0);
      tests++;
      if ({v_wdata[5], v_wdata[8], v_wdata[9]} !== 12'hAA5) begin
         fails++; $display("FAIL two_wdata: got %h want aa5", {v_wdata[5], v_wdata[8], v_wdata[9]});
      end
      tests++;
      if (v_end !== (64'd1 << 12)) begin
         fails++; $display("FAIL two_endinput: got %h want %h", v_end, 64'd1 << 12);
      end
      tests++;
      if (v_done !== (64'd1 << 14)) begin
         fails++; $display("FAIL two_done: got %h want %h", v_done, 64'd1 << 14);
      end
      tests++;
      if (v_err !== '0) begin
         fails++; $display("FAIL two_err: got %h want 0", v_err);
      end
      for (int i = 0; i < 6; i++) begin
         pop(v, d);
         tests++;
         if ({v, d} !== {1'b1, (i < 3) ? 32'h6666_6666 : 32'h3333_3333}) begin
            fails++; $display("FAIL two_fifo%0d: got %b/%h", i, v, d);
         end
      end
   endtask

   task automatic test_bad_num;
      logic seen;
      for (int t = 0; t < 2; t++) begin
         seen = 1'b0;
         start = 1'b1; num_w = (t == 0) ? 4'd0 : 4'd9;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 4; c++) begin
            seen = seen | ipf_ready | busy;
            @(negedge clk);
         end
         tests++;
         if (seen !== 1'b0) begin
            fails++; $display("FAIL bad_num_%0d: engine kicked, want ignored", num_w);
         end
      end
   endtask

   task automatic test_fifo_admission;
      logic v; logic [31:0] d; logic seen; logic [31:0] exp;
      session(4, 32'hA0, 32'hB0, 1'b1, 0);
      tests++;
      if (v_err !== '0) begin
         fails++; $display("FAIL adm_fill_err: got %h want 0", v_err);
      end
      for (int i = 0; i < 2; i++) pop(v, d);
      seen = 1'b0;
      start = 1'b1; num_w = 4'd8;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         seen = seen | ipf_ready | busy;
         @(negedge clk);
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL adm_reject: start accepted with 22 free, want ignored");
      end
      for (int i = 0; i < 2; i++) pop(v, d);
      tests++;
      if (d !== 32'hB0) begin
         fails++; $display("FAIL adm_pop4: got %h want b0", d);
      end
      session(8, 32'hC0, 32'hD0, 1'b1, 0);
      tests++;
      if ({v_ready[1], v_end, v_done} !== {1'b1, 64'd1 << 36, 64'd1 << 38}) begin
         fails++; $display("FAIL adm_accept: ready %b end %h done %h", v_ready[1], v_end, v_done);
      end
      tests++;
      if (v_err !== '0) begin
         fails++; $display("FAIL adm_err: got %h want 0", v_err);
      end
      for (int e = 0; e < 32; e++) begin
         exp = (e < 8) ? res_of(e + 4, 32'hA0, 32'hB0) : res_of(e - 8, 32'hC0, 32'hD0);
         pop(v, d);
         tests++;
         if ({v, d} !== {1'b1, exp}) begin
            fails++; $display("FAIL adm_drain%0d: got %b/%h want 1/%h", e, v, d, exp);
         end
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL adm_empty: out_valid %b want 0", out_valid);
      end
   endtask

   task automatic test_no_finish;
      logic v; logic [31:0] d;
      session(1, 32'h77, 32'h0, 1'b0, 0);
      tests++;
      if (v_err !== ((64'd1 << 10) | (64'd1 << 11))) begin
         fails++; $display("FAIL nofin_err: got %h want c00", v_err);
      end
      tests++;
      if ({v_done, v_irst} !== {64'd1 << 10, 64'd1 << 10}) begin
         fails++; $display("FAIL nofin_done_rst: done %h rst %h want bit 10", v_done, v_irst);
      end
      for (int i = 0; i < 3; i++) pop(v, d);
      tests++;
      if (err !== 1'b1) begin
         fails++; $display("FAIL nofin_sticky: err %b want 1", err);
      end
      session(1, 32'h78, 32'h0, 1'b1, 0);
      tests++;
      if (v_err !== '0) begin
         fails++; $display("FAIL nofin_clear: got %h want 0", v_err);
      end
      for (int i = 0; i < 3; i++) pop(v, d);
   endtask

   task automatic test_reset_mid;
      logic v; logic [31:0] d;
      load(1'b0, 3'd0, 8'h01); load(1'b0, 3'd1, 8'h02); load(1'b0, 3'd2, 8'h03);
      load(1'b1, 3'd0, 8'h07);
      session(1, 32'h44, 32'h0, 1'b1, 7);
      tests++;
      if (snap_zero !== 1'b1) begin
         fails++; $display("FAIL midrst_outputs: some output nonzero after rst at T+7");
      end
      @(negedge clk);
      tests++;
      if ({ld_ready, busy, out_valid} !== 3'b100) begin
         fails++; $display("FAIL midrst_idle: {ld_ready,busy,out_valid}=%b want 100",
                           {ld_ready, busy, out_valid});
      end
      load(1'b0, 3'd0, 8'h0A); load(1'b0, 3'd1, 8'h0B); load(1'b0, 3'd2, 8'h0C);
      load(1'b1, 3'd0, 8'h03);
      session(1, 32'h88, 32'h0, 1'b1, 0);
      tests++;
      if ({v_idata[2], v_idata[3], v_idata[4], v_wdata[5]} !== 28'h0A0B0C3) begin
         fails++; $display("FAIL midrst_data: got %h want 0a0b0c3",
                           {v_idata[2], v_idata[3], v_idata[4], v_wdata[5]});
      end
      tests++;
      if ({v_done, v_err} !== {64'd1 << 10, 64'd0}) begin
         fails++; $display("FAIL midrst_done_err: done %h err %h", v_done, v_err);
      end
      for (int i = 0; i < 3; i++) begin
         pop(v, d);
         tests++;
         if ({v, d} !== {1'b1, 32'h88}) begin
            fails++; $display("FAIL midrst_fifo%0d: got %b/%h want 1/88", i, v, d);
         end
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL midrst_empty: out_valid %b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two();
      test_bad_num();
      test_fifo_admission();
      test_no_finish();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
